// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Execute-stage HI/LO unit. Runs MULT/MULTU (shift-add) and DIV/DIVU
// (restoring division) one bit per cycle, and executes MTHI/MTLO in a single
// cycle. Owns the architectural HI/LO registers and requests a pipeline hold
// while a multiply or divide is in flight.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   E-stage instruction valid with a HI/LO write
//   op     in   3'b000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//               100 MTHI, 101 MTLO, others no-op
//   src_a  in   rs value: multiplicand / dividend / MTHI-MTLO data
//   src_b  in   rt value: multiplier / divisor
//   flush  in   cancel the E-stage instruction (any state)
//   stall  out  pipeline hold request (combinational)
//   done   out  one-cycle pulse in the cycle a mul/div result becomes visible
//   hi     out  HI register
//   lo     out  LO register
//
// Timing: with start seen in cycle 0, stall is high in cycles 0..WIDTH and
// the new HI/LO plus the done pulse appear in cycle WIDTH+1.
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q;   // 1: divide in flight, 0: multiply
    logic               neg_lo_q;   // negate product / quotient at the end
    logic               neg_hi_q;   // remainder takes the dividend sign
    logic               div0_q;     // divisor was zero
    logic [WIDTH-1:0]   raw_a_q;    // unmodified dividend for divide-by-zero
    logic [WIDTH-1:0]   opnd_q;     // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   acc_q;      // product high half / partial remainder
    logic [WIDTH-1:0]   low_q;      // multiplier bits / dividend->quotient
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    // ---------------------------------------------------------------------
    // Operation decode and operand magnitudes
    // ---------------------------------------------------------------------
    logic             op_muldiv;
    logic             op_div;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign op_muldiv = (op[2] == 1'b0);
    assign op_div    = op[1];
    assign op_signed = ~op[0];
    assign a_neg     = op_signed & src_a[WIDTH-1];
    assign b_neg     = op_signed & src_b[WIDTH-1];
    // Two's-complement negation of the most negative value wraps to itself,
    // which read as unsigned is the correct magnitude.
    assign mag_a     = a_neg ? (~src_a + 1'b1) : src_a;
    assign mag_b     = b_neg ? (~src_b + 1'b1) : src_b;

    logic accept_muldiv;
    assign accept_muldiv = (state_q == S_IDLE) && start && !flush && op_muldiv;

    // Hold request is combinational so the pipeline freezes in the very cycle
    // the operation is accepted; reset overrides everything.
    assign stall = !rst && (accept_muldiv || (state_q == S_RUN));

    // ---------------------------------------------------------------------
    // One iteration of the datapath
    // ---------------------------------------------------------------------
    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift {sum, low} right by one. After WIDTH steps {acc, low} holds
    // the full 2*WIDTH-bit unsigned product.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_n;
    logic [WIDTH-1:0] mul_low_n;

    assign mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc_n = mul_sum[WIDTH:1];
    assign mul_low_n = {mul_sum[0], low_q[WIDTH-1:1]};

    // Divide (restoring): shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The shifted remainder can be WIDTH+1
    // bits wide; when its top bit is set the subtraction always succeeds and
    // the true difference fits in WIDTH bits, so the wrapped WIDTH-bit
    // difference is exact.
    logic [WIDTH:0]   div_shift;
    logic             div_borrow;
    logic [WIDTH-1:0] div_sub;
    logic             div_fit;
    logic [WIDTH-1:0] div_acc_n;
    logic [WIDTH-1:0] div_low_n;

    assign div_shift              = {acc_q, low_q[WIDTH-1]};
    assign {div_borrow, div_sub}  = {1'b0, div_shift[WIDTH-1:0]} - {1'b0, opnd_q};
    assign div_fit                = div_shift[WIDTH] | ~div_borrow;
    assign div_acc_n              = div_fit ? div_sub : div_shift[WIDTH-1:0];
    assign div_low_n              = {low_q[WIDTH-2:0], div_fit};

    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_low;

    assign step_acc = is_div_q ? div_acc_n : mul_acc_n;
    assign step_low = is_div_q ? div_low_n : mul_low_n;

    // ---------------------------------------------------------------------
    // Sign correction of the final iteration's result
    // ---------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    assign prod_mag = {step_acc, step_low};
    assign prod_fix = neg_lo_q ? (~prod_mag + 1'b1) : prod_mag;
    assign quo_fix  = neg_lo_q ? (~step_low + 1'b1) : step_low;
    assign rem_fix  = neg_hi_q ? (~step_acc + 1'b1) : step_acc;

    always_comb begin
        fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                // Divide by zero does not trap: all-ones quotient and the
                // dividend handed back untouched as the remainder.
                fin_hi = raw_a_q;
                fin_lo = '1;
            end else begin
                fin_hi = rem_fix;
                fin_lo = quo_fix;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM and architectural registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            raw_a_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                // Cancel whatever is in flight; HI/LO keep their old values.
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (op_muldiv) begin
                                state_q  <= S_RUN;
                                cnt_q    <= '0;
                                is_div_q <= op_div;
                                div0_q   <= (src_b == '0);
                                raw_a_q  <= src_a;
                                acc_q    <= '0;
                                // Quotient/product sign differs iff operand
                                // signs differ; remainder follows dividend.
                                neg_lo_q <= a_neg ^ b_neg;
                                neg_hi_q <= a_neg;
                                if (op_div) begin
                                    opnd_q <= mag_b;
                                    low_q  <= mag_a;
                                end else begin
                                    opnd_q <= mag_a;
                                    low_q  <= mag_b;
                                end
                            end else if (op == OP_MTHI) begin
                                hi_q <= src_a;
                            end else if (op == OP_MTLO) begin
                                lo_q <= src_a;
                            end
                        end
                    end
                    S_RUN: begin
                        acc_q <= step_acc;
                        low_q <= step_low;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            hi_q    <= fin_hi;
                            lo_q    <= fin_lo;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;   // {hi, lo}
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain arithmetic on 64-bit integers.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] qv;
        logic [63:0] rv;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (o)
            OP_MULT:  res = sa * sb;
            OP_MULTU: res = {32'h0, a} * {32'h0, b};
            OP_DIV: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    qv = q;
                    rv = r;
                    res = {rv[31:0], qv[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Issue one mul/div and check latency, stall length and result.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] req);
        int          stall_cycles;
        int          done_cyc;
        logic [63:0] got;
        stall_cycles = 0;
        done_cyc     = -1;
        got          = '0;
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            if (done) begin
                done_cyc = c;
                got      = {hi, lo};
                break;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        start = 1'b0;
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h (req %h) stall=%0d done@%0d",
                 name, o, a, b, got[63:32], got[31:0], req, stall_cycles, done_cyc);
        chk({name, ".done_cycle"}, 64'(done_cyc), 64'(W + 1));
        chk({name, ".stall_cycles"}, 64'(stall_cycles), 64'(W + 1));
        chk({name, ".result"}, got, req);
    endtask

    vec_t vecs[10];

    initial begin
        logic [63:0] prior;
        logic        seen_done;
        logic        seen_stall;
        logic        changed;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[5] = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF};
        vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[8] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000};
        vecs[9] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF};

        // Reset with a pending start: stall must stay low.
        rst   = 1'b1;
        start = 1'b1;
        op    = OP_MULT;
        src_a = 32'h1;
        src_b = 32'h1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset.stall", 64'(stall), 64'(0));
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("reset.hilo", {hi, lo}, 64'h0);
        chk("reset.done", 64'(done), 64'(0));
        chk("reset.stall_after", 64'(stall), 64'(0));
        $display("reset hi=%h lo=%h stall=%b done=%b", hi, lo, stall, done);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = 32'($urandom_range(1, 9));
            if (i % 4 == 2) rb = -32'($urandom_range(1, 9));
            run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb));
        end

        // MTHI then MTLO back to back: single cycle, never stalls
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_MTHI;
        src_a = 32'hAAAA_0000;
        @(negedge clk);
        chk("mthi.stall", 64'(stall), 64'(0));
        @(posedge clk);
        #1;
        op    = OP_MTLO;
        src_a = 32'h0000_5555;
        @(negedge clk);
        chk("mtlo.stall", 64'(stall), 64'(0));
        chk("mthi.hi", 64'(hi), 64'hAAAA_0000);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("mtlo.hilo", {hi, lo}, 64'hAAAA_0000_0000_5555);
        chk("mtlo.done", 64'(done), 64'(0));
        $display("mthi/mtlo hi=%h lo=%h", hi, lo);

        // Undefined op and flushed MTHI are both ignored
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_NOP;
        src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("nop.stall", 64'(stall), 64'(0));
        @(posedge clk);
        #1;
        op    = OP_MTHI;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_mthi.stall", 64'(stall), 64'(0));
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("nop_flush.hilo", {hi, lo}, 64'hAAAA_0000_0000_5555);
        $display("nop/flushed mthi hi=%h lo=%h", hi, lo);

        // Flush in RUN cycle 10 of a DIV
        prior = {hi, lo};
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_DIV;
        src_a = 32'd100;
        src_b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush.stall_during", 64'(stall), 64'(1));
        @(posedge clk);
        #1;
        flush = 1'b0;
        seen_done  = 1'b0;
        seen_stall = 1'b0;
        changed    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) chk("flush.stall_next", 64'(stall), 64'(0));
            if (done) seen_done = 1'b1;
            if (stall) seen_stall = 1'b1;
            if ({hi, lo} !== prior) changed = 1'b1;
        end
        chk("flush.no_done", 64'(seen_done), 64'(0));
        chk("flush.no_stall", 64'(seen_stall), 64'(0));
        chk("flush.hilo_kept", 64'(changed), 64'(0));
        $display("flush div hi=%h lo=%h done_seen=%b", hi, lo, seen_done);

        // Reset in RUN cycle 5 of a MULTU
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_MULTU;
        src_a = 32'd5;
        src_b = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.stall_forced", 64'(stall), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.hilo", {hi, lo}, 64'h0);
        seen_done  = 1'b0;
        seen_stall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (stall) seen_stall = 1'b1;
        end
        chk("rst_mid.no_done", 64'(seen_done), 64'(0));
        chk("rst_mid.no_stall", 64'(seen_stall), 64'(0));
        $display("reset mid-op hi=%h lo=%h", hi, lo);

        // Unit works again after the abort
        run_op("recover", OP_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global timeout
    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
